inc_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit incrementer between two requesters (A and B). Each requester owns a count register, and every granted request increments that register by one through the shared incrementer. The block also publishes the compare result C = cnt_a - cnt_b (mod 2^WIDTH), plus equal and greater-than flags. It sits between the two increment sources and the shared incrementer/comparator datapath, and it sequences all access to that datapath.

---
 rtl/inc_arbiter_pkg.sv | 18 +
 rtl/inc_cmp_dp.sv | 31 +++
 rtl/inc_arbiter.sv | 149 ++++++++++++++
 tb/tb_inc_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/inc_arbiter_pkg.sv
// inc_arbiter_pkg
//   Shared definitions for the round-robin incrementer arbiter:
//   FSM state encoding, priority pointer values and the default
//   counter width. Imported by inc_arbiter and inc_cmp_dp.
package inc_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_e;

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

endpackage

// File: rtl/inc_cmp_dp.sv
// inc_cmp_dp
//   Shared combinational datapath: one incrementer plus the
//   subtract/compare logic that produces the published result.
// Ports:
//   op      in  WIDTH  operand latched by the arbiter
//   cnt_a   in  WIDTH  post-update value of counter A
//   cnt_b   in  WIDTH  post-update value of counter B
//   op_inc  out WIDTH  op + 1, wrapping at 2^WIDTH
//   diff    out WIDTH  cnt_a - cnt_b, modulo 2^WIDTH
//   eq      out 1      cnt_a == cnt_b
//   a_gt_b  out 1      cnt_a > cnt_b, unsigned
module inc_cmp_dp
  import inc_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] op,
  input  logic [WIDTH-1:0] cnt_a,
  input  logic [WIDTH-1:0] cnt_b,
  output logic [WIDTH-1:0] op_inc,
  output logic [WIDTH-1:0] diff,
  output logic             eq,
  output logic             a_gt_b
);

  assign op_inc = op + WIDTH'(1);
  assign diff   = cnt_a - cnt_b;
  assign eq     = (cnt_a == cnt_b);
  assign a_gt_b = (cnt_a > cnt_b);

endmodule

// File: rtl/inc_arbiter.sv
// inc_arbiter
//   Round-robin controller sharing one incrementer between two
//   requesters. Each grant takes two cycles (IDLE -> BUSY_x -> IDLE):
//   the operand is latched on the grant edge and written back as
//   op + 1 at the end of the BUSY cycle. The difference/compare
//   outputs are registered from the post-update counter values.
// Ports:
//   ck      in  1      clock, rising edge
//   rst     in  1      synchronous reset, active-low
//   req_a   in  1      level-sensitive increment request from A
//   req_b   in  1      level-sensitive increment request from B
//   clr     in  1      synchronous clear of both counters
//   ack_a   out 1      one-cycle pulse during A's BUSY cycle
//   ack_b   out 1      one-cycle pulse during B's BUSY cycle
//   busy    out 1      FSM is in BUSY_A or BUSY_B
//   C       out WIDTH  cnt_a - cnt_b modulo 2^WIDTH
//   eq      out 1      cnt_a == cnt_b
//   a_gt_b  out 1      cnt_a > cnt_b, unsigned
module inc_arbiter
  import inc_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int INIT_PRIO = 0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             clr,
  output logic             ack_a,
  output logic             ack_b,
  output logic             busy,
  output logic [WIDTH-1:0] C,
  output logic             eq,
  output logic             a_gt_b
);

  localparam logic PRIO_RESET = (INIT_PRIO != 0) ? PRIO_B : PRIO_A;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] c_q;
  logic             eq_q, a_gt_b_q;

  logic             grant_a, grant_b;
  logic [WIDTH-1:0] op_inc, diff;
  logic             dp_eq, dp_gt;

  inc_cmp_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .op     (op_q),
    .cnt_a  (cnt_a_d),
    .cnt_b  (cnt_b_d),
    .op_inc (op_inc),
    .diff   (diff),
    .eq     (dp_eq),
    .a_gt_b (dp_gt)
  );

  // Priority only breaks ties; a lone requester always wins.
  assign grant_a = req_a && (!req_b || (prio_q == PRIO_A));
  assign grant_b = req_b && !grant_a;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    op_d    = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_a) begin
          state_d = BUSY_A;
          op_d    = cnt_a_q;
          ack_a_d = 1'b1;
        end else if (grant_b) begin
          state_d = BUSY_B;
          op_d    = cnt_b_q;
          ack_b_d = 1'b1;
        end
      end
      BUSY_A: begin
        cnt_a_d = op_inc;
        prio_d  = PRIO_B;
        state_d = IDLE;
      end
      BUSY_B: begin
        cnt_b_d = op_inc;
        prio_d  = PRIO_A;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over the BUSY write-back; the ack already issued stands.
    if (clr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q  <= IDLE;
      prio_q   <= PRIO_RESET;
      op_q     <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      c_q      <= '0;
      eq_q     <= 1'b1;
      a_gt_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      op_q     <= op_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      busy_q   <= busy_d;
      c_q      <= diff;
      eq_q     <= dp_eq;
      a_gt_b_q <= dp_gt;
    end
  end

  assign ack_a  = ack_a_q;
  assign ack_b  = ack_b_q;
  assign busy   = busy_q;
  assign C      = c_q;
  assign eq     = eq_q;
  assign a_gt_b = a_gt_b_q;

endmodule

// File: tb/tb_inc_arbiter.sv
`timescale 1ns/1ps
module tb_inc_arbiter;

  logic       ck = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       clr = 1'b0;
  logic       ack_a, ack_b, busy, eq, a_gt_b;
  logic [7:0] c_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rst_n;
    logic       ra;
    logic       rb;
    logic       cl;
    logic       e_ack_a;
    logic       e_ack_b;
    logic       e_busy;
    logic [7:0] e_c;
    logic       e_eq;
    logic       e_gt;
  } vec_t;

  vec_t vecs[$];

  inc_arbiter #(
    .WIDTH     (8),
    .INIT_PRIO (0)
  ) dut (
    .ck     (ck),
    .rst    (rst),
    .req_a  (req_a),
    .req_b  (req_b),
    .clr    (clr),
    .ack_a  (ack_a),
    .ack_b  (ack_b),
    .busy   (busy),
    .C      (c_out),
    .eq     (eq),
    .a_gt_b (a_gt_b)
  );

  always #2.5 ck = ~ck;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the next rising edge.
  task automatic drive(input logic r, input logic ra, input logic rb, input logic cl);
    @(negedge ck);
    rst   = r;
    req_a = ra;
    req_b = rb;
    clr   = cl;
    @(posedge ck);
    #1;
  endtask

  function automatic void add(input logic r, input logic ra, input logic rb, input logic cl,
                              input logic ea, input logic eb, input logic ebusy,
                              input logic [7:0] ec, input logic eeq, input logic egt);
    vec_t v;
    v.rst_n = r;   v.ra = ra;      v.rb = rb;       v.cl = cl;
    v.e_ack_a = ea; v.e_ack_b = eb; v.e_busy = ebusy;
    v.e_c = ec;    v.e_eq = eeq;   v.e_gt = egt;
    vecs.push_back(v);
  endfunction

  initial begin
    int na;
    int nb;

    // Reset held with both requests high, then a single A request.
    add(0, 1, 1, 0,  0, 0, 0,  8'd0, 1, 0);
    add(0, 1, 1, 0,  0, 0, 0,  8'd0, 1, 0);
    add(1, 1, 0, 0,  1, 0, 1,  8'd0, 1, 0);
    add(1, 0, 0, 0,  0, 0, 0,  8'd1, 0, 1);
    // Re-reset so the tie-break restarts from A, then hold both requests.
    add(0, 0, 0, 0,  0, 0, 0,  8'd0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      add(1, 1, 1, 0,  1, 0, 1,  8'd0, 1, 0);
      add(1, 1, 1, 0,  0, 0, 0,  8'd1, 0, 1);
      add(1, 1, 1, 0,  0, 1, 1,  8'd1, 0, 1);
      add(1, 1, 1, 0,  0, 0, 0,  8'd0, 1, 0);
    end
    add(1, 0, 0, 0,  0, 0, 0,  8'd0, 1, 0);
    // Counters are 5/5: grant A, clear during its BUSY cycle, then B wins the tie.
    add(1, 1, 0, 0,  1, 0, 1,  8'd0, 1, 0);
    add(1, 0, 0, 1,  0, 0, 0,  8'd0, 1, 0);
    add(1, 1, 1, 0,  0, 1, 1,  8'd0, 1, 0);
    add(1, 0, 0, 0,  0, 0, 0,  8'd255, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].ra, vecs[i].rb, vecs[i].cl);
      check($sformatf("v%0d_ack_a", i), 32'(ack_a),  32'(vecs[i].e_ack_a));
      check($sformatf("v%0d_ack_b", i), 32'(ack_b),  32'(vecs[i].e_ack_b));
      check($sformatf("v%0d_busy", i),  32'(busy),   32'(vecs[i].e_busy));
      check($sformatf("v%0d_C", i),     32'(c_out),  32'(vecs[i].e_c));
      check($sformatf("v%0d_eq", i),    32'(eq),     32'(vecs[i].e_eq));
      check($sformatf("v%0d_gt", i),    32'(a_gt_b), 32'(vecs[i].e_gt));
      $display("vec %0d: rst=%0b ra=%0b rb=%0b clr=%0b -> ack_a=%0b ack_b=%0b busy=%0b C=%0d eq=%0b gt=%0b",
               i, vecs[i].rst_n, vecs[i].ra, vecs[i].rb, vecs[i].cl,
               ack_a, ack_b, busy, c_out, eq, a_gt_b);
    end

    // Held req_a for 16 cycles: ack every other cycle, 8 in total.
    drive(0, 0, 0, 0);
    na = 0;
    for (int k = 1; k <= 16; k++) begin
      drive(1, 1, 0, 0);
      check($sformatf("held_a_ack_c%0d", k), 32'(ack_a), 32'(k % 2));
      if (ack_a) na++;
    end
    check("held_a_count", 32'(na), 32'd8);
    check("held_a_C", 32'(c_out), 32'd8);
    $display("held A: acks=%0d C=%0d", na, c_out);
    nb = 0;
    for (int k = 1; k <= 16; k++) begin
      drive(1, 0, 1, 0);
      if (ack_b) nb++;
    end
    check("held_b_count", 32'(nb), 32'd8);
    check("held_b_C", 32'(c_out), 32'd0);
    check("held_b_eq", 32'(eq), 32'd1);
    $display("held B: acks=%0d C=%0d eq=%0b", nb, c_out, eq);

    // Wrap: cnt_b = 3, then 255 A increments, then one more.
    drive(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) drive(1, 0, 1, 0);
    for (int k = 0; k < 510; k++) drive(1, 1, 0, 0);
    check("wrap_pre_C", 32'(c_out), 32'd252);
    check("wrap_pre_gt", 32'(a_gt_b), 32'd1);
    $display("pre-wrap: C=%0d gt=%0b", c_out, a_gt_b);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    check("wrap_C", 32'(c_out), 32'd253);
    check("wrap_gt", 32'(a_gt_b), 32'd0);
    check("wrap_eq", 32'(eq), 32'd0);
    $display("post-wrap: C=%0d gt=%0b eq=%0b", c_out, a_gt_b, eq);

    // Reset during BUSY_B: no ack, outputs back to reset values, prio back to A.
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    check("rstb_pre_C", 32'(c_out), 32'd1);
    drive(1, 0, 1, 0);
    check("rstb_busy_ack_b", 32'(ack_b), 32'd1);
    drive(0, 0, 0, 0);
    check("rstb_ack_b", 32'(ack_b), 32'd0);
    check("rstb_busy", 32'(busy), 32'd0);
    check("rstb_C", 32'(c_out), 32'd0);
    check("rstb_eq", 32'(eq), 32'd1);
    check("rstb_gt", 32'(a_gt_b), 32'd0);
    drive(1, 1, 1, 0);
    check("rstb_regrant_a", 32'(ack_a), 32'd1);
    check("rstb_regrant_b", 32'(ack_b), 32'd0);
    drive(1, 0, 0, 0);
    check("rstb_post_C", 32'(c_out), 32'd1);
    $display("reset-in-busy: ack_a=%0b C=%0d", ack_a, c_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
